// File: rtl/iir_biquad_tdm_pkg.sv
// iir_pkg: shared constants, state encoding and helpers for the TDM biquad cascade.
package iir_pkg;

    localparam int unsigned NTAP = 5;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    typedef enum logic [1:0] {StIdle, StMac, StUpd, StDone} state_e;

    // Full-precision accumulator width: five products plus headroom.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned coef_w);
        return data_w + coef_w + 4;
    endfunction

    // Passthrough bank value for one tap: unity b0, every other tap zero.
    function automatic logic [31:0] pass_coef(input int unsigned tap, input int unsigned frac_w);
        return (tap == 0) ? (32'd1 << frac_w) : 32'd0;
    endfunction

endpackage

// File: rtl/iir_biquad_tdm_if.sv
// Sample stream in/out of the biquad cascade.
interface iir_biquad_tdm_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH_W   = 1
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] in_data;
    logic                     bypass;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ch, in_data, bypass,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, bypass,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/iir_mac_sat.sv
// Shared multiply-accumulate with round-half-up, shift and saturation of the result.
module iir_mac_sat
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 18,
    parameter int unsigned FRAC_W = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     load,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);
    localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) <<< (DATA_W - 1));
    localparam logic signed [DATA_W-1:0] YMAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] YMIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  shf;

    assign prod     = coef * data;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Accumulate one product per enabled cycle; load restarts the sum for a new stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= (load ? '0 : acc_q) + (sub ? -prod_ext : prod_ext);
        end
    end

    // Round half-up toward +inf, drop the fraction, clamp to the sample range.
    always_comb begin
        rnd = acc_q + HALF;
        shf = rnd >>> FRAC_W;
        sat = 1'b0;
        y   = shf[DATA_W-1:0];
        if (shf > MAXV) begin
            y   = YMAX;
            sat = 1'b1;
        end else if (shf < MINV) begin
            y   = YMIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Time-multiplexed DF-I biquad cascade over NCH interleaved channels with a
// double-buffered coefficient bank and one shared multiplier.
module iir_biquad_tdm
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 18,
    parameter int unsigned FRAC_W = 14,
    parameter int unsigned NCH    = 2,
    parameter int unsigned NSTAGE = 2,
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned CA_W  = $clog2(NTAP * NSTAGE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    iir_biquad_tdm_if.slave          bus,
    input  logic                     clr,
    input  logic                     coef_we,
    input  logic [CA_W-1:0]          coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     coef_commit,
    output logic                     ovf
);
    localparam int unsigned NCOEF = NTAP * NSTAGE;
    localparam int unsigned ST_W  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [ST_W-1:0] LAST_STAGE = ST_W'(NSTAGE - 1);

    state_e                   state_q;
    logic                     in_ready_q, out_valid_q, ovf_q, pend_q;
    logic [ST_W-1:0]          stage_q;
    logic [2:0]               tap_q;
    logic [CH_W-1:0]          ch_q, out_ch_q;
    logic signed [DATA_W-1:0] x_q, out_data_q;
    logic signed [DATA_W-1:0] x1_q [NSTAGE][NCH];
    logic signed [DATA_W-1:0] x2_q [NSTAGE][NCH];
    logic signed [DATA_W-1:0] y1_q [NSTAGE][NCH];
    logic signed [DATA_W-1:0] y2_q [NSTAGE][NCH];
    logic signed [COEF_W-1:0] shadow_q [NCOEF];
    logic signed [COEF_W-1:0] active_q [NCOEF];

    logic                     accept, ch_ok, sat;
    logic [CA_W-1:0]          coef_idx;
    logic signed [DATA_W-1:0] operand, y;

    // clr blocks acceptance combinationally so no sample sneaks in on the clear cycle.
    assign bus.in_ready  = in_ready_q & ~clr;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign ovf           = ovf_q;

    assign accept   = bus.in_valid & bus.in_ready;
    assign ch_ok    = {1'b0, bus.in_ch} < (CH_W + 1)'(NCH);
    assign coef_idx = CA_W'(stage_q * NTAP) + CA_W'(tap_q);

    // Select the multiplier's data operand for the current tap.
    always_comb begin
        operand = x_q;
        unique case (tap_q)
            TAP_B1:  operand = x1_q[stage_q][ch_q];
            TAP_B2:  operand = x2_q[stage_q][ch_q];
            TAP_A1:  operand = y1_q[stage_q][ch_q];
            TAP_A2:  operand = y2_q[stage_q][ch_q];
            default: operand = x_q;
        endcase
    end

    iir_mac_sat #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clr),
        .en    (state_q == StMac),
        .load  (tap_q == TAP_B0),
        .sub   (tap_q >= TAP_A1),
        .coef  (active_q[coef_idx]),
        .data  (operand),
        .y     (y),
        .sat   (sat)
    );

    // Sequencer: accept, walk stages and taps, present the result for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            stage_q     <= '0;
            tap_q       <= '0;
            ch_q        <= '0;
            x_q         <= '0;
        end else if (clr) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            stage_q     <= '0;
            tap_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept && ch_ok) begin
                        ch_q       <= bus.in_ch;
                        x_q        <= bus.in_data;
                        stage_q    <= '0;
                        tap_q      <= TAP_B0;
                        in_ready_q <= 1'b0;
                        state_q    <= bus.bypass ? StDone : StMac;
                    end
                end
                StMac: begin
                    if (tap_q == TAP_A2) begin
                        state_q <= StUpd;
                    end else begin
                        tap_q <= tap_q + 3'd1;
                    end
                end
                StUpd: begin
                    x_q   <= y;
                    ovf_q <= ovf_q | sat;
                    tap_q <= TAP_B0;
                    if (stage_q == LAST_STAGE) begin
                        state_q <= StDone;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                        state_q <= StMac;
                    end
                end
                StDone: begin
                    out_valid_q <= 1'b1;
                    out_ch_q    <= ch_q;
                    out_data_q  <= x_q;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Per-stage, per-channel history; shifted only once the stage result is final.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int c = 0; c < NCH; c++) begin
                    x1_q[s][c] <= '0;
                    x2_q[s][c] <= '0;
                    y1_q[s][c] <= '0;
                    y2_q[s][c] <= '0;
                end
            end
        end else if (clr) begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int c = 0; c < NCH; c++) begin
                    x1_q[s][c] <= '0;
                    x2_q[s][c] <= '0;
                    y1_q[s][c] <= '0;
                    y2_q[s][c] <= '0;
                end
            end
        end else if (state_q == StUpd) begin
            x2_q[stage_q][ch_q] <= x1_q[stage_q][ch_q];
            x1_q[stage_q][ch_q] <= x_q;
            y2_q[stage_q][ch_q] <= y1_q[stage_q][ch_q];
            y1_q[stage_q][ch_q] <= y;
        end
    end

    // Coefficient banks: shadow written freely, copied to active only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= COEF_W'(pass_coef(i % NTAP, FRAC_W));
                active_q[i] <= COEF_W'(pass_coef(i % NTAP, FRAC_W));
            end
            pend_q <= 1'b0;
        end else begin
            if (coef_we && (int'(coef_addr) < NCOEF)) begin
                shadow_q[coef_addr] <= coef_wdata;
            end
            if (pend_q && (state_q == StIdle)) begin
                for (int i = 0; i < NCOEF; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                pend_q <= 1'b0;
            end
            if (coef_commit) begin
                pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/iir_biquad_tdm.md
# iir_biquad_tdm

Parametrised, time-multiplexed IIR low-pass filter for the lock-in demodulator back end. It filters NCH interleaved channels (e.g. I and Q mixer outputs) through a cascade of NSTAGE Direct-Form-I biquads. Coefficients are runtime-loadable through a double-buffered bank, and the block uses one shared multiplier. It replaces fixed shift-add filters between the mixers and the output decimator.

## Interface
- DATA_W, 16: signed sample width (in and out)
- COEF_W, 18: signed coefficient width
- FRAC_W, 14: coefficient fraction bits; 1.0 = 2^FRAC_W
- NCH, 2: number of interleaved channels
- NSTAGE, 2: number of cascaded biquads (filter order 2*NSTAGE)
- clk  in  1  system clock (32 MHz)
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample strobe
- in_ready  out  1  block can accept a sample
- in_ch  in  max(1,clog2(NCH))  channel index of in_data
- in_data  in  DATA_W  signed input sample
- bypass  in  1  sampled at accept; pass the sample unfiltered
- clr  in  1  synchronous clear of all filter history and of ovf
- coef_we  in  1  write the shadow coefficient bank
- coef_addr  in  clog2(5*NSTAGE)  index = stage*5 + tap, with taps b0,b1,b2,a1,a2 = 0..4
- coef_wdata  in  COEF_W  signed coefficient
- coef_commit  in  1  request a shadow-to-active bank copy
- out_valid  out  1  one-cycle result strobe
- out_ch  out  width of in_ch  channel of out_data
- out_data  out  DATA_W  signed filtered sample
- ovf  out  1  sticky: a saturation has occurred since the last clr or reset

## Operation
- Per stage s and channel c: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2. Stage 0 input is in_data; stage s>0 input is the stage s−1 output.
- Accumulator is ACC_W = DATA_W+COEF_W+4 bits, signed, full precision.
- Per-stage result: add 2^(FRAC_W−1), arithmetic shift right by FRAC_W, then saturate to DATA_W.
  - Rounding is half-up toward +inf: 1.5 → 2, −1.5 → −1.
  - Saturation sets ovf.
- History x1, x2, y1, y2 is kept per stage per channel. It is updated only after that stage's result is final.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch ch/data/bypass. Go to DONE if bypass, else MAC.
  - MAC: one product per cycle, taps 0..4 of the current stage, then go to UPD.
  - UPD: round, saturate and shift history. Go to MAC for the next stage, or DONE after the last stage.
  - DONE: out_valid=1, then return to IDLE.
- Bypass: out_data = latched in_data. History is untouched and ovf is unchanged.
- in_ch ≥ NCH: the sample is accepted and dropped. The FSM stays in IDLE and no out_valid is issued.
- Coefficients:
  - coef_we writes the shadow bank at any time; coef_addr ≥ 5*NSTAGE is ignored.
  - coef_commit sets a pending flag. The copy occurs on the first cycle the FSM is in IDLE, so the active bank never changes mid-sample.
  - If coef_we and the copy occur in the same cycle, the copy uses the pre-write shadow value.
- clr has priority over everything:
  - It zeroes all history and ovf and aborts any sample in flight (no out_valid).
  - The FSM goes to IDLE and in_ready=0 during the clr cycle.
  - Coefficient banks are kept.
- Reset values:
  - in_ready=1, out_valid=0, out_ch=0, out_data=0, ovf=0.
  - History is 0 and the commit-pending flag is 0.
  - Both banks reset to passthrough: each stage b0=2^FRAC_W, all other taps 0.

## Timing
- Accepting edge: the rising edge where in_valid && in_ready.
- Filtered path: out_valid is high for exactly one cycle, 6·NSTAGE+1 edges after the accepting edge (13 for NSTAGE=2). in_ready is low from the accepting edge until DONE exits.
- Bypass path: out_valid 1 edge after the accepting edge.
- Minimum accept spacing: 6·NSTAGE+2 cycles filtered, 2 cycles bypass.
- out_ch/out_data change only with out_valid and hold their value between strobes.
- rst_n low mid-sample: outputs take reset values immediately (asynchronous), and the sample is lost.

## Structure
- Package iir_pkg holds:
  - the ACC_W calculation function;
  - tap index constants (TAP_B0..TAP_A2, NTAP=5);
  - the FSM state enum;
  - the passthrough coefficient constant function.
- Sub-module iir_mac_sat: signed COEF_W×DATA_W multiply-accumulate with clear, plus round-half-up/shift/saturate and an overflow flag. It is instantiated once.
- Top level holds the FSM, stage/tap counters, history register arrays [NSTAGE][NCH] and both coefficient banks.

## Test plan
- Reset, passthrough: in_data=1000 ch0 → out_data=1000, out_ch=0, out_valid exactly 13 cycles later; ovf=0.
- Gain and rounding: stage0 b0=8192, commit, inputs 3, −3, 16384 → outputs 2, −1, 8192.
- Recursion and channel isolation: stage0 a1=−8192, commit; step of 1000 on ch0 → 1000, 1500, 1750, 1875. An interleaved ch1 constant 200 → 200 every time.
- Saturation: stage0 b0=32767, input 32767 → 32767 with ovf=1; −32768 → −32768. clr → ovf=0 and history zero.
- Shadow bank: coef_we without commit → output unchanged. Commit asserted during MAC → the current sample uses old coefficients and the next sample uses new ones.
- Abort and bypass:
  - rst_n low mid-MAC → out_valid never fires, in_ready=1, passthrough restored.
  - clr mid-MAC → no out_valid.
  - bypass=1 with input −5 → −5 one edge after accept.
